serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_sub_if.sv | 26 ++
 rtl/serial_sub_digit_sub.sv | 24 ++
 rtl/serial_sub.sv | 133 +++++++++++++
 tb/tb_serial_sub.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_AMB = 1'b0;
    localparam logic MODE_BMA = 1'b1;

    function automatic bit width_ok(input int width, input int digit);
        return (digit > 0) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_sub_if.sv
// Request/result bundle between a subtractor client (master) and the serial_sub core (slave).
interface serial_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output start, mode, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    modport slave (
        input  start, mode, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
endinterface

// File: rtl/serial_sub_digit_sub.sv
// DIGIT-bit ripple full subtractor, purely combinational (zero latency).
// No handshake: d/bo follow m/s/bi within the same cycle.
module digit_sub #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] m,
    input  logic [DIGIT-1:0] s,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] brw;

    assign brw[0] = bi;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        assign d[i]       = m[i] ^ s[i] ^ brw[i];
        assign brw[i+1]   = (~m[i] & s[i]) | (~(m[i] ^ s[i]) & brw[i]);
    end

    assign bo = brw[DIGIT];

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle WIDTH-bit subtractor, DIGIT bits per cycle, LSD first; done K+1 cycles after start (K=WIDTH/DIGIT).
// Backpressure: start is only accepted while busy=0; requests during RUN are dropped.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic         clk,
    input  logic         rst,
    serial_sub_if.slave  io
);

    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    if (!width_ok(WIDTH, DIGIT)) begin : g_bad_cfg
        $error("serial_sub: WIDTH must be a positive multiple of DIGIT");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] m_dig;
    logic [DIGIT-1:0] s_dig;
    logic [DIGIT-1:0] d_dig;
    logic             bo_dig;

    assign m_dig = m_q[int'(cnt_q) * DIGIT +: DIGIT];
    assign s_dig = s_q[int'(cnt_q) * DIGIT +: DIGIT];

    digit_sub #(.DIGIT(DIGIT)) u_digit (
        .m  (m_dig),
        .s  (s_dig),
        .bi (brw_q),
        .d  (d_dig),
        .bo (bo_dig)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        m_d     = m_q;
        s_d     = s_q;
        part_d  = part_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;

        case (state_q)
            RUN: begin
                part_d[int'(cnt_q) * DIGIT +: DIGIT] = d_dig;
                brw_d = bo_dig;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = part_d;
                    bout_d  = bo_dig;
                    zero_d  = (part_d == '0);
                    ovf_d   = (m_q[WIDTH-1] != s_q[WIDTH-1]) && (part_d[WIDTH-1] != m_q[WIDTH-1]);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
                if (io.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    part_d  = '0;
                    brw_d   = io.bin;
                    m_d     = (io.mode == MODE_BMA) ? io.b : io.a;
                    s_d     = (io.mode == MODE_BMA) ? io.a : io.b;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
            part_q  <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            m_q     <= m_d;
            s_q     <= s_d;
            part_q  <= part_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.diff = diff_q;
    assign io.bout = bout_q;
    assign io.zero = zero_q;
    assign io.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub across four WIDTH/DIGIT configurations.
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] start_v = '0;
    logic       mode_s = 1'b0;
    logic       bin_s = 1'b0;
    logic [7:0] a_s = '0;
    logic [7:0] b_s = '0;

    always #5 clk = ~clk;

    serial_sub_if #(.WIDTH(8)) if81 ();
    serial_sub_if #(.WIDTH(8)) if84 ();
    serial_sub_if #(.WIDTH(8)) if88 ();
    serial_sub_if #(.WIDTH(3)) if31 ();

    assign if81.start = start_v[0];
    assign if84.start = start_v[1];
    assign if88.start = start_v[2];
    assign if31.start = start_v[3];
    assign if81.mode = mode_s; assign if84.mode = mode_s; assign if88.mode = mode_s; assign if31.mode = mode_s;
    assign if81.bin  = bin_s;  assign if84.bin  = bin_s;  assign if88.bin  = bin_s;  assign if31.bin  = bin_s;
    assign if81.a = a_s; assign if84.a = a_s; assign if88.a = a_s; assign if31.a = a_s[2:0];
    assign if81.b = b_s; assign if84.b = b_s; assign if88.b = b_s; assign if31.b = b_s[2:0];

    serial_sub #(.WIDTH(8), .DIGIT(1)) u81 (.clk(clk), .rst(rst), .io(if81));
    serial_sub #(.WIDTH(8), .DIGIT(4)) u84 (.clk(clk), .rst(rst), .io(if84));
    serial_sub #(.WIDTH(8), .DIGIT(8)) u88 (.clk(clk), .rst(rst), .io(if88));
    serial_sub #(.WIDTH(3), .DIGIT(1)) u31 (.clk(clk), .rst(rst), .io(if31));

    logic [3:0] done_v, busy_v, bout_v, zero_v, ovf_v;
    logic [7:0] diff_v [4];

    assign done_v = {if31.done, if88.done, if84.done, if81.done};
    assign busy_v = {if31.busy, if88.busy, if84.busy, if81.busy};
    assign bout_v = {if31.bout, if88.bout, if84.bout, if81.bout};
    assign zero_v = {if31.zero, if88.zero, if84.zero, if81.zero};
    assign ovf_v  = {if31.ovf,  if88.ovf,  if84.ovf,  if81.ovf};
    assign diff_v[0] = if81.diff;
    assign diff_v[1] = if84.diff;
    assign diff_v[2] = if88.diff;
    assign diff_v[3] = {5'b0, if31.diff};

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one request to unit u and waits (bounded) for its done pulse.
    // lat counts cycles after the start edge; -1 means the bound expired.
    task automatic run_op(input int u, input logic md, input logic [7:0] a, input logic [7:0] b,
                          input logic bi, output logic [7:0] d, output logic bo, output logic z,
                          output logic ov, output int lat, output int bcnt, output logic bsy_at_done);
        @(negedge clk);
        mode_s = md; a_s = a; b_s = b; bin_s = bi; start_v[u] = 1'b1;
        @(negedge clk);
        start_v[u] = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done_v[u] && lat < 40) begin
            if (busy_v[u]) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done_v[u]) lat = -1;
        d = diff_v[u]; bo = bout_v[u]; z = zero_v[u]; ov = ovf_v[u];
        bsy_at_done = busy_v[u];
    endtask

    typedef struct {
        logic       md;
        logic [7:0] a;
        logic [7:0] b;
        logic       bi;
        logic [7:0] d;
        logic       bo;
        logic       z;
        logic       ov;
    } vec_t;

    vec_t vecs [9];

    logic [7:0] d;
    logic       bo, z, ov, bad;
    int         lat, bcnt, ndone, last, ovl;
    logic [7:0] dsave;
    logic       bsave;
    logic [2:0] mm, ss;
    logic [3:0] full;
    int         sm, sv, tr;

    initial begin
        vecs[0] = '{1'b0, 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 8'h5A, 8'h59, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h12, 8'h35, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        for (int u = 0; u < 4; u++)
            check("reset_outs", {busy_v[u], done_v[u], bout_v[u], zero_v[u], ovf_v[u], diff_v[u]}, 32'h0);
        rst = 1'b0;

        // Bit-serial WIDTH=8 vectors: results, latency K+1=9, busy for exactly K=8 cycles.
        for (int i = 0; i < 9; i++) begin
            run_op(0, vecs[i].md, vecs[i].a, vecs[i].b, vecs[i].bi, d, bo, z, ov, lat, bcnt, bad);
            check("vec_diff", d, vecs[i].d);
            check("vec_bout", bo, vecs[i].bo);
            check("vec_zero", z, vecs[i].z);
            check("vec_ovf", ov, vecs[i].ov);
            check("vec_latency", lat, 9);
            check("vec_busy_cycles", bcnt, 8);
            check("vec_busy_at_done", bad, 1'b0);
        end

        // A start pulsed mid-RUN must be ignored: result and single done unchanged.
        @(negedge clk);
        mode_s = 1'b1; a_s = 8'h12; b_s = 8'h35; bin_s = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        mode_s = 1'b0; a_s = 8'hFF; b_s = 8'h00; bin_s = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        ndone = 0; dsave = '0; bsave = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[0]) begin ndone++; dsave = diff_v[0]; bsave = bout_v[0]; end
        end
        check("ignore_done_count", ndone, 1);
        check("ignore_diff", dsave, 8'h23);
        check("ignore_bout", bsave, 1'b0);

        // Reset asserted at cycle t+4 of a RUN clears everything; no done follows.
        @(negedge clk);
        mode_s = 1'b0; a_s = 8'h00; b_s = 8'h01; bin_s = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy", busy_v[0], 1'b1);
        check("midrun_diff_held", diff_v[0], 8'h23);
        rst = 1'b1;
        @(negedge clk);
        check("rst_midrun_outs", {busy_v[0], done_v[0], bout_v[0], zero_v[0], ovf_v[0], diff_v[0]}, 32'h0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done_v[0]) ndone++;
        end
        check("rst_no_done", ndone, 0);
        run_op(0, 1'b0, 8'h5A, 8'h59, 1'b1, d, bo, z, ov, lat, bcnt, bad);
        check("post_rst_diff", d, 8'h00);
        check("post_rst_zero", z, 1'b1);
        check("post_rst_latency", lat, 9);

        // DIGIT=4 (K=2) and DIGIT=8 (K=1) latency and results.
        run_op(1, 1'b0, 8'h35, 8'h12, 1'b0, d, bo, z, ov, lat, bcnt, bad);
        check("d4_diff", d, 8'h23);
        check("d4_latency", lat, 3);
        check("d4_busy_cycles", bcnt, 2);
        run_op(1, 1'b0, 8'h00, 8'h01, 1'b0, d, bo, z, ov, lat, bcnt, bad);
        check("d4_wrap", {bo, d}, 9'h1FF);
        run_op(2, 1'b0, 8'h80, 8'h01, 1'b0, d, bo, z, ov, lat, bcnt, bad);
        check("d8_diff", d, 8'h7F);
        check("d8_ovf", ov, 1'b1);
        check("d8_latency", lat, 2);
        check("d8_busy_cycles", bcnt, 1);
        run_op(2, 1'b1, 8'h12, 8'h35, 1'b1, d, bo, z, ov, lat, bcnt, bad);
        check("d8_swap", {bo, d}, 9'h022);

        // start held high on the K=2 unit: done every 3 cycles, never alongside busy.
        @(negedge clk);
        mode_s = 1'b0; a_s = 8'h35; b_s = 8'h12; bin_s = 1'b0; start_v[1] = 1'b1;
        ndone = 0; last = -1; ovl = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_v[1] && busy_v[1]) ovl++;
            if (done_v[1]) begin
                if (last >= 0) check("b2b_gap", c - last, 3);
                last = c;
                ndone++;
            end
        end
        start_v[1] = 1'b0;
        check("b2b_done_count", ndone, 4);
        check("b2b_overlap", ovl, 0);
        check("b2b_diff", diff_v[1], 8'h23);

        // WIDTH=3 exhaustive in both modes against a 4-bit / signed-range reference.
        for (int md = 0; md < 2; md++)
            for (int ai = 0; ai < 8; ai++)
                for (int bi = 0; bi < 8; bi++)
                    for (int ci = 0; ci < 2; ci++) begin
                        run_op(3, md[0], 8'(ai), 8'(bi), ci[0], d, bo, z, ov, lat, bcnt, bad);
                        mm = (md == 1) ? 3'(bi) : 3'(ai);
                        ss = (md == 1) ? 3'(ai) : 3'(bi);
                        full = {1'b0, mm} - {1'b0, ss} - 4'(ci);
                        sm = mm[2] ? int'(mm) - 8 : int'(mm);
                        sv = ss[2] ? int'(ss) - 8 : int'(ss);
                        tr = sm - sv - ci;
                        check("exh3", {lat, bo, d[2:0], z, ov},
                              {32'd4, full, (full[2:0] == 3'b000), ((tr < -4) || (tr > 3))});
                    end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
